// File: rtl/obi_mem_arbiter_if.sv
// Bus bundle for the two-master / one-slave OBI memory arbiter.
// The slave modport is the arbiter's view. The master modport is the
// surrounding environment: the fetch and data masters plus the memory.
interface obi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // instruction fetch port
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  // data port
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;
  // shared memory port
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter letting the fetch and data masters share one OBI
// memory. Request and response paths are purely combinational. A small
// in-order owner FIFO remembers which master issued each accepted request,
// so every response is steered back to the right master.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  obi_mem_arbiter_if.slave                     bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic                       last_grant;
  logic                       err;

  logic any_req;
  logic sel_data;
  logic full;
  logic mem_req;
  logic push;
  logic pop;
  logic head;

  // Advance a FIFO pointer, wrapping at the FIFO depth.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign any_req = bus.instr_req_i | bus.data_req_i;
  assign full    = (count == CW'(MAX_OUTSTANDING));
  // Outputs are held quiet while reset is asserted.
  assign mem_req = rst_ni & any_req & ~full;
  assign push    = mem_req & bus.mem_gnt_i;
  assign pop     = bus.mem_rvalid_i & (count != {CW{1'b0}});
  assign head    = owner_q[rd_ptr];

  // Pick the master to forward; on contention, the one not granted last.
  always_comb begin
    sel_data = 1'b0;
    case ({bus.instr_req_i, bus.data_req_i})
      2'b01:   sel_data = 1'b1;
      2'b10:   sel_data = 1'b0;
      2'b11:   sel_data = (last_grant == OWNER_INSTR);
      default: sel_data = 1'b0;
    endcase
  end

  // Forward the selected master's request fields to memory.
  always_comb begin
    bus.mem_req_o   = mem_req;
    bus.mem_addr_o  = {ADDR_WIDTH{1'b0}};
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_wdata_o = 32'h0;
    if (!any_req) begin
      bus.mem_addr_o  = {ADDR_WIDTH{1'b0}};
      bus.mem_be_o    = 4'h0;
    end else if (sel_data) begin
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_be_o    = bus.data_be_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else begin
      bus.mem_addr_o  = bus.instr_addr_i;
      bus.mem_be_o    = 4'hF;
    end
  end

  // Steer the grant to the selected master and the response to the FIFO head owner.
  always_comb begin
    bus.instr_gnt_o    = push & ~sel_data;
    bus.data_gnt_o     = push & sel_data;
    bus.instr_rvalid_o = rst_ni & pop & (head == OWNER_INSTR);
    bus.data_rvalid_o  = rst_ni & pop & (head == OWNER_DATA);
    bus.instr_rdata_o  = bus.mem_rdata_i;
    bus.data_rdata_o   = bus.mem_rdata_i;
  end

  // Owner FIFO, outstanding count, round-robin history and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count      <= {CW{1'b0}};
      wr_ptr     <= {PW{1'b0}};
      rd_ptr     <= {PW{1'b0}};
      owner_q    <= {MAX_OUTSTANDING{1'b0}};
      last_grant <= OWNER_INSTR;
      err        <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_data;
        wr_ptr          <= ptr_inc(wr_ptr);
        last_grant      <= sel_data;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.mem_rvalid_i && (count == {CW{1'b0}})) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  assign outstanding_o = count;
  assign err_o         = err;
endmodule
